// File: rtl/serv_mem_responder.sv
// Word-addressed on-chip memory answering serv ibus fetches and dbus loads/stores
// with WAIT_STATES wait cycles. Optional range checking: define SERV_MEM_RANGE_CHECK_EN.
//
// state | meaning
// IDLE  | no transaction; arbitrate dbus over ibus
// WAIT  | request captured, wait counter running
// ACK   | one-cycle ack to owner; read data out, store written
// TURN  | owner drops cyc; a pending request on the other bus may be captured
module serv_mem_responder #(
  parameter int DEPTH_LOG2  = 6,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  output logic        o_range_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2,
    S_TURN = 2'd3
  } state_t;

  localparam state_t S_LAUNCH = (WAIT_STATES == 0) ? S_ACK : S_WAIT;

  state_t state, next_state;

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] cap_idx;
  logic [31:0]           cap_dat;
  logic [3:0]            cap_sel;
  logic                  cap_we;
  logic                  cap_oor;
  logic                  owner_d;
  logic [3:0]            wait_cnt;
  logic                  wait_done;
  logic [31:0]           ibus_rdt_q;
  logic [31:0]           dbus_rdt_q;
  logic [31:0]           rd_word;
  logic                  pick_d;
  logic                  pick_i;
  logic                  capture;
  logic                  owner_cyc;
  logic                  mem_we;
  logic                  ibus_oor;
  logic                  dbus_oor;
  logic [DEPTH_LOG2-1:0] ibus_idx;
  logic [DEPTH_LOG2-1:0] dbus_idx;
  logic                  unused_adr_bits;

  assign ibus_idx = i_ibus_adr[DEPTH_LOG2+1:2];
  assign dbus_idx = i_dbus_adr[DEPTH_LOG2+1:2];

`ifdef SERV_MEM_RANGE_CHECK_EN
  logic range_err_q;

  assign ibus_oor = |i_ibus_adr[31:DEPTH_LOG2+2];
  assign dbus_oor = |i_dbus_adr[31:DEPTH_LOG2+2];
  assign unused_adr_bits = ^{i_ibus_adr[1:0], i_dbus_adr[1:0]};

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      range_err_q <= 1'b0;
    end else if (state == S_ACK && cap_oor) begin
      range_err_q <= 1'b1;
    end
  end

  assign o_range_err = range_err_q;
`else
  assign ibus_oor = 1'b0;
  assign dbus_oor = 1'b0;
  assign unused_adr_bits = ^{i_ibus_adr[31:DEPTH_LOG2+2], i_ibus_adr[1:0],
                             i_dbus_adr[31:DEPTH_LOG2+2], i_dbus_adr[1:0]};
  assign o_range_err = 1'b0;
`endif

  // In TURN only the bus that was not just served may be captured, so a held
  // ibus request follows a dbus ack without an extra IDLE cycle.
  always_comb begin
    pick_d = 1'b0;
    pick_i = 1'b0;
    case (state)
      S_IDLE: begin
        pick_d = i_dbus_cyc;
        pick_i = !i_dbus_cyc && i_ibus_cyc;
      end
      S_TURN: begin
        pick_d = !owner_d && i_dbus_cyc;
        pick_i = owner_d && i_ibus_cyc;
      end
      default: begin
        pick_d = 1'b0;
        pick_i = 1'b0;
      end
    endcase
  end

  assign capture   = pick_d | pick_i;
  assign owner_cyc = owner_d ? i_dbus_cyc : i_ibus_cyc;
  assign wait_done = (wait_cnt == 4'd0);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (capture) next_state = S_LAUNCH;
      end
      S_WAIT: begin
        if (!owner_cyc)     next_state = S_IDLE;
        else if (wait_done) next_state = S_ACK;
      end
      S_ACK:   next_state = S_TURN;
      S_TURN:  next_state = capture ? S_LAUNCH : S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    o_ibus_ack = 1'b0;
    o_dbus_ack = 1'b0;
    o_ibus_rdt = ibus_rdt_q;
    o_dbus_rdt = dbus_rdt_q;
    if (state == S_ACK) begin
      if (owner_d) begin
        o_dbus_ack = 1'b1;
        if (!cap_we) o_dbus_rdt = rd_word;
      end else begin
        o_ibus_ack = 1'b1;
        o_ibus_rdt = rd_word;
      end
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cap_idx  <= '0;
      cap_dat  <= '0;
      cap_sel  <= '0;
      cap_we   <= 1'b0;
      cap_oor  <= 1'b0;
      owner_d  <= 1'b0;
      wait_cnt <= '0;
    end else if (capture) begin
      owner_d  <= pick_d;
      cap_idx  <= pick_d ? dbus_idx : ibus_idx;
      cap_oor  <= pick_d ? dbus_oor : ibus_oor;
      cap_dat  <= i_dbus_dat;
      cap_sel  <= i_dbus_sel;
      cap_we   <= pick_d & i_dbus_we;
      wait_cnt <= CNT_INIT;
    end else if (state == S_WAIT && !wait_done) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ibus_rdt_q <= '0;
      dbus_rdt_q <= '0;
    end else begin
      if (o_ibus_ack)            ibus_rdt_q <= rd_word;
      if (o_dbus_ack && !cap_we) dbus_rdt_q <= rd_word;
    end
  end

  assign rd_word = cap_oor ? 32'h0000_0000 : mem[cap_idx];
  assign mem_we  = (state == S_ACK) && owner_d && cap_we && !cap_oor;

  // Memory contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (cap_sel[b]) mem[cap_idx][8*b +: 8] <= cap_dat[8*b +: 8];
      end
    end
  end

endmodule
